// File: rtl/register_file_mp.sv
// Multi-port integer register file with dual write ports, optional
// write-to-read bypass, busy scoreboard and a debug read port.
module register_file_mp #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 32,
    parameter int                NUM_RD   = 2,
    parameter bit                BYPASS   = 1'b1,
    parameter int                INIT_IDX = 11,
    parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(1),
    localparam int               AW       = $clog2(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_RD*AW-1:0]     rs_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rs_data_o,
    output logic [NUM_RD-1:0]        rs_busy_o,
    input  logic                     w0_en_i,
    input  logic [AW-1:0]            w0_addr_i,
    input  logic [DATA_W-1:0]        w0_data_i,
    input  logic                     w1_en_i,
    input  logic [AW-1:0]            w1_addr_i,
    input  logic [DATA_W-1:0]        w1_data_i,
    input  logic                     alloc_en_i,
    input  logic [AW-1:0]            alloc_addr_i,
    input  logic [AW-1:0]            dbg_addr_i,
    output logic [DATA_W-1:0]        dbg_data_o,
    output logic                     busy_any_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  w0_hit;
    logic [DEPTH-1:0]  w1_hit;
    logic [DEPTH-1:0]  al_hit;

    // One-hot decode; bit 0 never hits, which keeps x0 and busy[0] at zero.
    always_comb begin
        w0_hit = '0;
        w1_hit = '0;
        al_hit = '0;
        for (int i = 1; i < DEPTH; i++) begin
            w0_hit[i] = w0_en_i && (w0_addr_i == AW'(i));
            w1_hit[i] = w1_en_i && (w1_addr_i == AW'(i));
            al_hit[i] = alloc_en_i && (alloc_addr_i == AW'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (i == INIT_IDX && i != 0) ? INIT_VAL : '0;
            end
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w1_hit[i]) begin
                    mem[i] <= w1_data_i;
                end else if (w0_hit[i]) begin
                    mem[i] <= w0_data_i;
                end
            end
            // A new allocation supersedes a completing producer.
            busy <= (busy & ~(w0_hit | w1_hit)) | al_hit;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
        logic              bsy;

        assign addr = rs_addr_i[k*AW +: AW];

        always_comb begin
            data = mem[addr];
            bsy  = busy[addr];
            if (BYPASS) begin
                if (w1_hit[addr]) begin
                    data = w1_data_i;
                end else if (w0_hit[addr]) begin
                    data = w0_data_i;
                end
                if ((w0_hit[addr] || w1_hit[addr]) && !al_hit[addr]) begin
                    bsy = 1'b0;
                end
            end
        end

        assign rs_data_o[k*DATA_W +: DATA_W] = data;
        assign rs_busy_o[k]                  = bsy;
    end

    assign dbg_data_o = mem[dbg_addr_i];
    assign busy_any_o = |busy;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed and model-based checks for register_file_mp.
module tb_register_file_mp;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instances a (BYPASS=1) and b (BYPASS=0) share every input.
    logic [9:0]  rs_addr;
    logic [63:0] a_rs_data, b_rs_data;
    logic [1:0]  a_rs_busy, b_rs_busy;
    logic        w0_en, w1_en, al_en;
    logic [4:0]  w0_addr, w1_addr, al_addr, dbg_addr;
    logic [31:0] w0_data, w1_data, a_dbg, b_dbg;
    logic        a_any, b_any;

    logic [11:0]  c_rs_addr;
    logic [191:0] c_rs_data;
    logic [2:0]   c_rs_busy;
    logic         c_w0_en, c_w1_en, c_al_en, c_any;
    logic [3:0]   c_w0_addr, c_w1_addr, c_al_addr, c_dbg_addr;
    logic [63:0]  c_w0_data, c_w1_data, c_dbg;

    int n_chk  = 0;
    int n_fail = 0;

    register_file_mp dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .rs_addr_i(rs_addr), .rs_data_o(a_rs_data), .rs_busy_o(a_rs_busy),
        .w0_en_i(w0_en), .w0_addr_i(w0_addr), .w0_data_i(w0_data),
        .w1_en_i(w1_en), .w1_addr_i(w1_addr), .w1_data_i(w1_data),
        .alloc_en_i(al_en), .alloc_addr_i(al_addr),
        .dbg_addr_i(dbg_addr), .dbg_data_o(a_dbg), .busy_any_o(a_any)
    );

    register_file_mp #(.BYPASS(1'b0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .rs_addr_i(rs_addr), .rs_data_o(b_rs_data), .rs_busy_o(b_rs_busy),
        .w0_en_i(w0_en), .w0_addr_i(w0_addr), .w0_data_i(w0_data),
        .w1_en_i(w1_en), .w1_addr_i(w1_addr), .w1_data_i(w1_data),
        .alloc_en_i(al_en), .alloc_addr_i(al_addr),
        .dbg_addr_i(dbg_addr), .dbg_data_o(b_dbg), .busy_any_o(b_any)
    );

    register_file_mp #(.DATA_W(64), .DEPTH(16), .NUM_RD(3)) dut_c (
        .clk_i(clk), .rst_ni(rst_n),
        .rs_addr_i(c_rs_addr), .rs_data_o(c_rs_data), .rs_busy_o(c_rs_busy),
        .w0_en_i(c_w0_en), .w0_addr_i(c_w0_addr), .w0_data_i(c_w0_data),
        .w1_en_i(c_w1_en), .w1_addr_i(c_w1_addr), .w1_data_i(c_w1_data),
        .alloc_en_i(c_al_en), .alloc_addr_i(c_al_addr),
        .dbg_addr_i(c_dbg_addr), .dbg_data_o(c_dbg), .busy_any_o(c_any)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w0_en = 0; w1_en = 0; al_en = 0;
    endtask

    task automatic rd(input logic [4:0] p0, input logic [4:0] p1);
        rs_addr = {p1, p0};
        #1;
    endtask

    logic [63:0] m [16];
    bit          mb [16];
    logic [3:0]  ca;
    logic [63:0] ed;
    bit          eb;
    bit          eany;

    initial begin
        rst_n = 0;
        idle();
        rs_addr = '0; dbg_addr = 5'd5;
        w0_addr = 0; w1_addr = 0; al_addr = 0;
        w0_data = 0; w1_data = 0;
        c_w0_en = 0; c_w1_en = 0; c_al_en = 0;
        c_w0_addr = 0; c_w1_addr = 0; c_al_addr = 0; c_dbg_addr = 0;
        c_w0_data = 0; c_w1_data = 0; c_rs_addr = 0;

        // Reset with a write held active
        w0_en = 1; w0_addr = 5; w0_data = 32'hAAAA_AAAA;
        tick(); tick();
        rst_n = 1; idle();
        rd(5, 11);
        chk("rst_r5", a_rs_data[31:0], 64'h0);
        chk("rst_r11", a_rs_data[63:32], 64'h1);
        chk("rst_busy", a_rs_busy, 64'h0);
        chk("rst_any", a_any, 64'h0);
        chk("rst_dbg5", a_dbg, 64'h0);
        chk("rst_b_r11", b_rs_data[63:32], 64'h1);

        // x0 writes and allocs dropped
        w0_en = 1; w0_addr = 0; w0_data = 32'hDEAD_BEEF;
        al_en = 1; al_addr = 0;
        rd(0, 0);
        chk("x0_same", a_rs_data[31:0], 64'h0);
        chk("x0_busy_same", a_rs_busy[0], 64'h0);
        tick(); idle(); #1;
        chk("x0_after", a_rs_data[31:0], 64'h0);
        chk("x0_busy_after", a_rs_busy[0], 64'h0);
        chk("x0_any", a_any, 64'h0);

        // Both ports hit addr 7: w1 wins
        w0_en = 1; w0_addr = 7; w0_data = 32'h1111;
        w1_en = 1; w1_addr = 7; w1_data = 32'h2222;
        rd(7, 7);
        chk("conf_byp", a_rs_data[31:0], 64'h2222);
        chk("conf_nobyp", b_rs_data[31:0], 64'h0);
        tick(); idle(); dbg_addr = 7; #1;
        chk("conf_next", a_rs_data[31:0], 64'h2222);
        chk("conf_b_next", b_rs_data[31:0], 64'h2222);
        chk("conf_dbg", a_dbg, 64'h2222);

        // Bypass off: read lags the write by one edge
        w0_en = 1; w0_addr = 3; w0_data = 32'h55;
        rd(0, 3);
        chk("nobyp_old", b_rs_data[63:32], 64'h0);
        chk("byp_new", a_rs_data[63:32], 64'h55);
        chk("dbg_no_byp", a_dbg, 64'h2222);
        dbg_addr = 3; #1;
        chk("dbg3_old", a_dbg, 64'h0);
        tick(); idle(); #1;
        chk("nobyp_next", b_rs_data[63:32], 64'h55);

        // Scoreboard
        al_en = 1; al_addr = 9;
        rd(9, 11);
        chk("sb_alloc_lat", a_rs_busy[0], 64'h0);
        tick(); idle(); #1;
        chk("sb_busy", a_rs_busy[0], 64'h1);
        chk("sb_any", a_any, 64'h1);
        chk("sb_b_busy", b_rs_busy[0], 64'h1);
        w1_en = 1; w1_addr = 9; w1_data = 32'h42;
        #1;
        chk("sb_clr_byp", a_rs_busy[0], 64'h0);
        chk("sb_data_byp", a_rs_data[31:0], 64'h42);
        chk("sb_b_busy_hold", b_rs_busy[0], 64'h1);
        chk("sb_b_data_old", b_rs_data[31:0], 64'h0);
        tick(); idle(); #1;
        chk("sb_any_clr", a_any, 64'h0);
        chk("sb_b_any_clr", b_any, 64'h0);
        chk("sb_b_data", b_rs_data[31:0], 64'h42);

        // Alloc and write in the same cycle: set wins
        al_en = 1; al_addr = 9;
        w0_en = 1; w0_addr = 9; w0_data = 32'h77;
        #1;
        chk("sb_aw_same", a_rs_busy[0], 64'h0);
        tick(); idle(); #1;
        chk("sb_aw_busy", a_rs_busy[0], 64'h1);
        chk("sb_aw_any", a_any, 64'h1);
        chk("sb_aw_data", a_rs_data[31:0], 64'h77);

        // Reset mid-sequence clears everything
        rst_n = 0;
        w0_en = 1; w0_addr = 9; w0_data = 32'h5;
        al_en = 1; al_addr = 4;
        tick();
        rst_n = 1; idle(); rd(9, 4);
        chk("mrst_any", a_any, 64'h0);
        chk("mrst_r9", a_rs_data[31:0], 64'h0);
        chk("mrst_busy4", a_rs_busy[1], 64'h0);
        rd(9, 11);
        chk("mrst_r11", a_rs_data[63:32], 64'h1);

        // Parametric instance against a reference model
        for (int i = 0; i < 16; i++) begin
            m[i] = (i == 11) ? 64'h1 : 64'h0;
            mb[i] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            c_w0_en = ($urandom_range(0, 2) != 0);
            c_w1_en = ($urandom_range(0, 2) == 0);
            c_al_en = ($urandom_range(0, 3) == 0);
            c_w0_addr = 4'($urandom_range(0, 15));
            c_w1_addr = 4'($urandom_range(0, 15));
            c_al_addr = 4'($urandom_range(0, 15));
            c_w0_data = {$urandom, $urandom};
            c_w1_data = {$urandom, $urandom};
            c_rs_addr = 12'($urandom);
            c_dbg_addr = 4'($urandom_range(0, 15));
            #1;
            for (int k = 0; k < 3; k++) begin
                ca = c_rs_addr[k*4 +: 4];
                ed = m[ca];
                eb = mb[ca];
                if (ca != 0 && c_w1_en && c_w1_addr == ca) ed = c_w1_data;
                else if (ca != 0 && c_w0_en && c_w0_addr == ca) ed = c_w0_data;
                if (ca != 0 && ((c_w0_en && c_w0_addr == ca) ||
                    (c_w1_en && c_w1_addr == ca)) &&
                    !(c_al_en && c_al_addr == ca)) eb = 0;
                chk("c_data", c_rs_data[k*64 +: 64], ed);
                chk("c_busy", c_rs_busy[k], 64'(eb));
            end
            chk("c_dbg", c_dbg, m[c_dbg_addr]);
            eany = 0;
            for (int i = 1; i < 16; i++) eany |= mb[i];
            chk("c_any", c_any, 64'(eany));
            tick();
            if (c_w0_en && c_w0_addr != 0) begin
                m[c_w0_addr] = c_w0_data;
                mb[c_w0_addr] = 0;
            end
            if (c_w1_en && c_w1_addr != 0) begin
                m[c_w1_addr] = c_w1_data;
                mb[c_w1_addr] = 0;
            end
            if (c_al_en && c_al_addr != 0) mb[c_al_addr] = 1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
